// File: rtl/pir_input_conditioner.sv
// Two-channel PIR front end: synchronize, debounce, edge-pulse and count motion events after a warm-up lockout.
// Optional stuck-high detection is enabled by defining PIR_STUCK_DETECT_EN.
module pir_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned WARMUP_CYCLES   = 50_000_000,
  parameter int unsigned STUCK_CYCLES    = 500_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pir_raw_1,
  input  logic       pir_raw_2,
  output logic       pir_clean_1,
  output logic       pir_clean_2,
  output logic       motion_pulse_1,
  output logic       motion_pulse_2,
  output logic [7:0] event_count_1,
  output logic [7:0] event_count_2,
  output logic       warmup_done,
  output logic       stuck_fault_1,
  output logic       stuck_fault_2
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
`ifdef PIR_STUCK_DETECT_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
`endif

  if (DEBOUNCE_CYCLES == 0 || STUCK_CYCLES == 0) begin : g_param_check
    $error("pir_input_conditioner: DEBOUNCE_CYCLES and STUCK_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {
    ST_WARMUP,
    ST_IDLE,
    ST_QUAL_HIGH,
    ST_ACTIVE,
    ST_QUAL_LOW
  } state_t;

  logic [WW-1:0] r_warm_cnt;
  logic          w_warm_done;
  logic [1:0]    w_raw;
  logic [1:0]    w_clean;
  logic [1:0]    w_pulse;
  logic [1:0]    w_fault;
  logic [7:0]    w_evt [2];

  assign w_raw = {pir_raw_2, pir_raw_1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm_cnt <= '0;
    end else if (r_warm_cnt != WW'(WARMUP_CYCLES)) begin
      r_warm_cnt <= r_warm_cnt + WW'(1);
    end
  end

  assign w_warm_done = (r_warm_cnt == WW'(WARMUP_CYCLES));

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          r_meta;
    logic          r_sync;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_deb;
    logic [DW-1:0] w_deb_nxt;
    logic [DW-1:0] w_deb_inc;
    logic          w_deb_hit;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic [7:0]    r_evt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= w_raw[g];
        r_sync <= r_meta;
      end
    end

    // The counter is zero in IDLE and ACTIVE, so w_deb_hit there covers DEBOUNCE_CYCLES == 1.
    assign w_deb_inc = r_deb + DW'(1);
    assign w_deb_hit = (w_deb_inc == DW'(DEBOUNCE_CYCLES));

    always_comb begin
      w_state_nxt = r_state;
      w_deb_nxt   = r_deb;
      w_pulse_nxt = 1'b0;
      case (r_state)
        ST_WARMUP: begin
          w_deb_nxt = '0;
          if (w_warm_done) w_state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (r_sync) begin
            if (w_deb_hit) begin
              w_state_nxt = ST_ACTIVE;
              w_deb_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_QUAL_HIGH;
              w_deb_nxt   = w_deb_inc;
            end
          end
        end
        ST_QUAL_HIGH: begin
          if (!r_sync) begin
            w_state_nxt = ST_IDLE;
            w_deb_nxt   = '0;
          end else if (w_deb_hit) begin
            w_state_nxt = ST_ACTIVE;
            w_deb_nxt   = '0;
            w_pulse_nxt = 1'b1;
          end else begin
            w_deb_nxt = w_deb_inc;
          end
        end
        ST_ACTIVE: begin
          if (!r_sync) begin
            if (w_deb_hit) begin
              w_state_nxt = ST_IDLE;
              w_deb_nxt   = '0;
            end else begin
              w_state_nxt = ST_QUAL_LOW;
              w_deb_nxt   = w_deb_inc;
            end
          end
        end
        ST_QUAL_LOW: begin
          if (r_sync) begin
            w_state_nxt = ST_ACTIVE;
            w_deb_nxt   = '0;
          end else if (w_deb_hit) begin
            w_state_nxt = ST_IDLE;
            w_deb_nxt   = '0;
          end else begin
            w_deb_nxt = w_deb_inc;
          end
        end
        default: begin
          w_state_nxt = ST_WARMUP;
          w_deb_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_WARMUP;
        r_deb   <= '0;
        r_pulse <= 1'b0;
        r_evt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_deb   <= w_deb_nxt;
        r_pulse <= w_pulse_nxt;
        if (w_pulse_nxt && (r_evt != 8'hFF)) r_evt <= r_evt + 8'd1;
      end
    end

    assign w_clean[g] = (r_state == ST_ACTIVE) || (r_state == ST_QUAL_LOW);
    assign w_pulse[g] = r_pulse;
    assign w_evt[g]   = r_evt;

`ifdef PIR_STUCK_DETECT_EN
    logic [SW-1:0] r_stuck_cnt;
    logic [SW-1:0] w_stuck_inc;
    logic          r_fault;

    assign w_stuck_inc = r_stuck_cnt + SW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stuck_cnt <= '0;
        r_fault     <= 1'b0;
      end else begin
        if (!w_clean[g]) begin
          r_stuck_cnt <= '0;
        end else if (r_stuck_cnt != SW'(STUCK_CYCLES)) begin
          r_stuck_cnt <= w_stuck_inc;
        end
        if (w_state_nxt == ST_IDLE) begin
          r_fault <= 1'b0;
        end else if (w_clean[g] && (w_stuck_inc == SW'(STUCK_CYCLES))) begin
          r_fault <= 1'b1;
        end
      end
    end

    assign w_fault[g] = r_fault;
`else
    assign w_fault[g] = 1'b0;
`endif
  end

  assign pir_clean_1    = w_clean[0];
  assign pir_clean_2    = w_clean[1];
  assign motion_pulse_1 = w_pulse[0];
  assign motion_pulse_2 = w_pulse[1];
  assign event_count_1  = w_evt[0];
  assign event_count_2  = w_evt[1];
  assign stuck_fault_1  = w_fault[0];
  assign stuck_fault_2  = w_fault[1];
  assign warmup_done    = w_warm_done;

endmodule

// File: tb/tb_pir_input_conditioner.sv
// Self-checking bench for pir_input_conditioner against a run-length debounce model.
// Stuck-fault expectations follow PIR_STUCK_DETECT_EN.
module tb_pir_input_conditioner;
  localparam int unsigned D = 4;
  localparam int unsigned W = 16;
  localparam int unsigned S = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pir_raw_1 = 1'b0;
  logic       pir_raw_2 = 1'b0;
  logic       pir_clean_1, pir_clean_2;
  logic       motion_pulse_1, motion_pulse_2;
  logic [7:0] event_count_1, event_count_2;
  logic       warmup_done;
  logic       stuck_fault_1, stuck_fault_2;

  int checks = 0;
  int errors = 0;

  pir_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .WARMUP_CYCLES  (W),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pir_raw_1     (pir_raw_1),
    .pir_raw_2     (pir_raw_2),
    .pir_clean_1   (pir_clean_1),
    .pir_clean_2   (pir_clean_2),
    .motion_pulse_1(motion_pulse_1),
    .motion_pulse_2(motion_pulse_2),
    .event_count_1 (event_count_1),
    .event_count_2 (event_count_2),
    .warmup_done   (warmup_done),
    .stuck_fault_1 (stuck_fault_1),
    .stuck_fault_2 (stuck_fault_2)
  );

  always #5 clk = ~clk;

  // Reference model: edges since release, raw delay line, run length of samples disagreeing with clean.
  int m_edges;
  bit m_clean [2];
  bit m_pulse [2];
  bit m_fault [2];
  bit m_d1 [2];
  bit m_d2 [2];
  int m_run [2];
  int m_scnt [2];
  int m_evt [2];

  task automatic model_reset();
    m_edges = 0;
    for (int c = 0; c < 2; c++) begin
      m_clean[c] = 0; m_pulse[c] = 0; m_fault[c] = 0;
      m_d1[c] = 0; m_d2[c] = 0; m_run[c] = 0; m_scnt[c] = 0; m_evt[c] = 0;
    end
  endtask

  task automatic tick();
    bit r [2];
    r[0] = pir_raw_1;
    r[1] = pir_raw_2;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      bit was;
      was = m_clean[c];
      m_pulse[c] = 0;
      // Samples only count once the lockout ended before the previous edge.
      if (m_edges <= int'(W)) begin
        m_clean[c] = 0;
        m_run[c] = 0;
      end else if (m_d2[c] != m_clean[c]) begin
        m_run[c]++;
        if (m_run[c] == int'(D)) begin
          m_clean[c] = !m_clean[c];
          m_run[c] = 0;
          if (m_clean[c]) begin
            m_pulse[c] = 1;
            if (m_evt[c] < 255) m_evt[c]++;
          end
        end
      end else begin
        m_run[c] = 0;
      end
      m_scnt[c] = was ? m_scnt[c] + 1 : 0;
`ifdef PIR_STUCK_DETECT_EN
      if (!m_clean[c]) m_fault[c] = 0;
      else if (m_scnt[c] == int'(S)) m_fault[c] = 1;
`else
      m_fault[c] = 0;
`endif
      m_d2[c] = m_d1[c];
      m_d1[c] = r[c];
    end
    m_edges++;
  endtask

  function automatic logic [6:0] obs_flags();
    return {pir_clean_2, pir_clean_1, motion_pulse_2, motion_pulse_1, stuck_fault_2, stuck_fault_1, warmup_done};
  endfunction

  function automatic logic [6:0] exp_flags();
    return {m_clean[1], m_clean[0], m_pulse[1], m_pulse[0], m_fault[1], m_fault[0], (m_edges >= int'(W))};
  endfunction

  function automatic logic [15:0] exp_counts();
    return {m_evt[1][7:0], m_evt[0][7:0]};
  endfunction

  task automatic finish_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_flags() !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp %b", obs_flags(), 7'b0);
    end
    checks++;
    if ({event_count_2, event_count_1} !== 16'h0) begin
      errors++; $display("FAIL reset_counts got %h exp %h", {event_count_2, event_count_1}, 16'h0);
    end
    finish_reset();
  endtask

  task automatic test_warmup();
    int first_done;
    first_done = -1;
    reset_n = 1'b0;
    pir_raw_1 = 1'b1;
    pir_raw_2 = 1'b0;
    finish_reset();
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (warmup_done && first_done < 0) first_done = t;
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL warmup_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
      checks++;
      if ({event_count_2, event_count_1} !== exp_counts()) begin
        errors++; $display("FAIL warmup_counts t=%0d got %h exp %h", t, {event_count_2, event_count_1}, exp_counts());
      end
    end
    checks++;
    if (first_done !== int'(W)) begin
      errors++; $display("FAIL warmup_done_cycle got %0d exp %0d", first_done, W);
    end
    pir_raw_1 = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    int pulses, rise;
    reset_n = 1'b0;
    pir_raw_1 = 1'b0;
    finish_reset();
    repeat (W + 4) tick();
    pulses = 0;
    pir_raw_1 = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      if (t == 4) pir_raw_1 = 1'b0;
      tick();
      pulses += int'(motion_pulse_1) + int'(pir_clean_1);
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL glitch_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL glitch_suppressed got %0d exp 0", pulses);
    end
    pulses = 0;
    rise = -1;
    pir_raw_1 = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 10) pir_raw_1 = 1'b0;
      if (motion_pulse_1) pulses++;
      if (pir_clean_1 && rise < 0) rise = t;
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL pulse10_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
    end
    checks++;
    if (rise !== int'(D) + 2) begin
      errors++; $display("FAIL clean_latency got %0d exp %0d", rise, D + 2);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL pulse_count got %0d exp 1", pulses);
    end
    checks++;
    if (event_count_1 !== 8'd1) begin
      errors++; $display("FAIL event_count_1 got %0d exp 1", event_count_1);
    end
  endtask

  task automatic test_simultaneous();
    int both, single, e1, e2;
    both = 0;
    single = 0;
    e1 = m_evt[0];
    e2 = m_evt[1];
    pir_raw_1 = 1'b1;
    pir_raw_2 = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 10) begin pir_raw_1 = 1'b0; pir_raw_2 = 1'b0; end
      if (motion_pulse_1 && motion_pulse_2) both++;
      else if (motion_pulse_1 || motion_pulse_2) single++;
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL simul_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
    end
    checks++;
    if (both !== 1 || single !== 0) begin
      errors++; $display("FAIL simul_pulses got both=%0d single=%0d exp both=1 single=0", both, single);
    end
    checks++;
    if ({event_count_2, event_count_1} !== {8'(e2 + 1), 8'(e1 + 1)}) begin
      errors++; $display("FAIL simul_counts got %h exp %h", {event_count_2, event_count_1}, {8'(e2 + 1), 8'(e1 + 1)});
    end
  endtask

  task automatic test_stuck();
    int fault_rise, fault_fall, seen;
    fault_rise = -1;
    fault_fall = -1;
    seen = 0;
    pir_raw_1 = 1'b0;
    pir_raw_2 = 1'b0;
    repeat (12) tick();
    for (int t = 1; t <= 60; t++) begin
      pir_raw_1 = (t <= 40);
      tick();
      if (stuck_fault_1) seen++;
      if (stuck_fault_1 && fault_rise < 0) fault_rise = t;
      if (!stuck_fault_1 && fault_rise >= 0 && fault_fall < 0) fault_fall = t;
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL stuck_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
    end
`ifdef PIR_STUCK_DETECT_EN
    checks++;
    if (fault_rise !== int'(D + 2 + S)) begin
      errors++; $display("FAIL stuck_rise got %0d exp %0d", fault_rise, D + 2 + S);
    end
    checks++;
    if (fault_fall !== int'(40 + D + 2)) begin
      errors++; $display("FAIL stuck_clear got %0d exp %0d", fault_fall, 40 + D + 2);
    end
`else
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL stuck_tied_low got %0d exp 0", seen);
    end
`endif
  endtask

  task automatic test_random();
    for (int t = 1; t <= 400; t++) begin
      if ($urandom_range(0, 4) == 0) pir_raw_1 = ~pir_raw_1;
      if ($urandom_range(0, 4) == 0) pir_raw_2 = ~pir_raw_2;
      tick();
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL random_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
      checks++;
      if ({event_count_2, event_count_1} !== exp_counts()) begin
        errors++; $display("FAIL random_counts t=%0d got %h exp %h", t, {event_count_2, event_count_1}, exp_counts());
      end
    end
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 260; p++) begin
      int hi, lo;
      hi = $urandom_range(4, 7);
      lo = $urandom_range(4, 8);
      for (int k = 0; k < hi + lo; k++) begin
        pir_raw_2 = (k < hi);
        pir_raw_1 = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if ({event_count_2, event_count_1} !== exp_counts()) begin
          errors++; $display("FAIL sat_counts p=%0d got %h exp %h", p, {event_count_2, event_count_1}, exp_counts());
        end
      end
    end
    pir_raw_1 = 1'b0;
    pir_raw_2 = 1'b0;
    repeat (8) tick();
    checks++;
    if (event_count_2 !== 8'd255) begin
      errors++; $display("FAIL event_count_2_sat got %0d exp 255", event_count_2);
    end
  endtask

  task automatic test_reset_mid();
    int first_done;
    first_done = -1;
    pir_raw_1 = 1'b0;
    pir_raw_2 = 1'b0;
    repeat (10) tick();
    pir_raw_1 = 1'b1;
    repeat (8) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_flags() !== 7'b0) begin
      errors++; $display("FAIL midreset_flags got %b exp %b", obs_flags(), 7'b0);
    end
    checks++;
    if ({event_count_2, event_count_1} !== 16'h0) begin
      errors++; $display("FAIL midreset_counts got %h exp %h", {event_count_2, event_count_1}, 16'h0);
    end
    finish_reset();
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (warmup_done && first_done < 0) first_done = t;
      checks++;
      if (obs_flags() !== exp_flags()) begin
        errors++; $display("FAIL rewarm_flags t=%0d got %b exp %b", t, obs_flags(), exp_flags());
      end
    end
    checks++;
    if (first_done !== int'(W)) begin
      errors++; $display("FAIL rewarm_done_cycle got %0d exp %0d", first_done, W);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warmup();
    test_glitch();
    test_simultaneous();
    test_stuck();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
